guess_checker: RTL and testbench



---
 rtl/guess_checker.sv | 207 ++++++++++++++++++++
 tb/tb_guess_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_checker.sv
// -----------------------------------------------------------------------------
// guess_checker
//
// Bounded number-guessing game driven by the on-chip random stream.
//
// On start (from IDLE, WIN or LOSE) the current random_number is folded into
// 0..MAX_VALUE and kept as the hidden secret. Guesses arrive over a
// valid/ready handshake. Each accepted guess is compared one cycle later,
// producing a higher/lower/correct hint and consuming one try. The game ends
// in WIN (correct guess) or LOSE (tries exhausted). Only then does the
// secret appear on secret_out.
//
// Handshake: a guess transfers on a rising clk edge where guess_valid and
// guess_ready are both 1. guess_ready is 1 only in PLAY. guess_valid may be
// held high; a transfer happens at most every second edge, because the
// compare cycle (CHECK) drops guess_ready for one cycle.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous, active-low reset
//   random_number in   free-running generator value (0..MAX_VALUE+1)
//   start         in   level-sampled request to begin a new game
//   guess_valid   in   a guess is present on guess
//   guess         in   guessed value
//   guess_ready   out  a guess can be accepted this cycle
//   higher        out  last guess was below the secret
//   lower         out  last guess was above the secret
//   correct       out  last guess equalled the secret
//   tries_left    out  guesses remaining in the current game
//   won           out  game ended with a correct guess
//   lost          out  game ended with tries exhausted
//   secret_out    out  secret when won or lost, otherwise 0
//   dbg_state     out  current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module guess_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 10,
    parameter int MAX_TRIES = 5    // legal range 1..7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] random_number,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             guess_ready,
    output logic             higher,
    output logic             lower,
    output logic             correct,
    output logic [2:0]       tries_left,
    output logic             won,
    output logic             lost,
    output logic [WIDTH-1:0] secret_out,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_e;

    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] FOLD_SUB  = WIDTH'(MAX_VALUE + 1);
    localparam logic [2:0]       TRIES_INI = 3'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] secret_q, secret_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [2:0]       tries_q, tries_d;
    logic             ready_q, ready_d;
    logic             higher_q, higher_d;
    logic             lower_q, lower_d;
    logic             correct_q, correct_d;
    logic             won_q, won_d;
    logic             lost_q, lost_d;
    logic [WIDTH-1:0] sout_q, sout_d;

    // The generator can emit MAX_VALUE+1; fold such values back into range.
    logic [WIDTH-1:0] folded;
    assign folded = (random_number > MAX_V) ? (random_number - FOLD_SUB)
                                            : random_number;

    // Remaining tries after the guess currently being checked. CHECK is only
    // entered with tries_q >= 1, so this never wraps in use.
    logic [2:0] tries_dec;
    assign tries_dec = tries_q - 3'd1;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            secret_q  <= '0;
            guess_q   <= '0;
            tries_q   <= '0;
            ready_q   <= 1'b0;
            higher_q  <= 1'b0;
            lower_q   <= 1'b0;
            correct_q <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            sout_q    <= '0;
        end else begin
            state_q   <= state_d;
            secret_q  <= secret_d;
            guess_q   <= guess_d;
            tries_q   <= tries_d;
            ready_q   <= ready_d;
            higher_q  <= higher_d;
            lower_q   <= lower_d;
            correct_q <= correct_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
            sout_q    <= sout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        tries_d   = tries_q;
        higher_d  = higher_q;
        lower_d   = lower_q;
        correct_d = correct_q;
        won_d     = won_q;
        lost_d    = lost_q;
        sout_d    = sout_q;

        unique case (state_q)
            // IDLE, WIN and LOSE share the same restart behaviour; the end
            // states additionally hold their result until start arrives.
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d   = S_PLAY;
                    secret_d  = folded;
                    tries_d   = TRIES_INI;
                    higher_d  = 1'b0;
                    lower_d   = 1'b0;
                    correct_d = 1'b0;
                    won_d     = 1'b0;
                    lost_d    = 1'b0;
                    sout_d    = '0;
                end
            end

            // start is deliberately not looked at here: a game in progress
            // cannot be abandoned except by reset.
            S_PLAY: begin
                if (guess_valid) begin
                    guess_d = guess;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // A correct guess still spends its try, so a last-try win
                // leaves tries_left at 0 but reports won, not lost.
                tries_d = tries_dec;
                if (guess_q == secret_q) begin
                    correct_d = 1'b1;
                    higher_d  = 1'b0;
                    lower_d   = 1'b0;
                    won_d     = 1'b1;
                    sout_d    = secret_q;
                    state_d   = S_WIN;
                end else begin
                    correct_d = 1'b0;
                    higher_d  = (guess_q < secret_q);
                    lower_d   = (guess_q > secret_q);
                    if (tries_dec == 3'd0) begin
                        lost_d  = 1'b1;
                        sout_d  = secret_q;
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // guess_ready is registered: it tracks the state being entered.
        ready_d = (state_d == S_PLAY);
    end

    assign guess_ready = ready_q;
    assign higher      = higher_q;
    assign lower       = lower_q;
    assign correct     = correct_q;
    assign tries_left  = tries_q;
    assign won         = won_q;
    assign lost        = lost_q;
    assign secret_out  = sout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_guess_checker.sv
module tb_guess_checker;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] random_number = '0;
  logic         start = 1'b0;
  logic         guess_valid = 1'b0;
  logic [W-1:0] guess = '0;
  logic         guess_ready, higher, lower, correct, won, lost;
  logic [2:0]   tries_left;
  logic [W-1:0] secret_out;
  logic [2:0]   dbg_state;

  guess_checker #(.WIDTH(W), .MAX_VALUE(10), .MAX_TRIES(5)) dut (
    .clk(clk), .reset_n(reset_n), .random_number(random_number),
    .start(start), .guess_valid(guess_valid), .guess(guess),
    .guess_ready(guess_ready), .higher(higher), .lower(lower),
    .correct(correct), .tries_left(tries_left), .won(won), .lost(lost),
    .secret_out(secret_out), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // reference model: the game as described, in plain integers
  int m_secret = 0;
  int m_tries  = 0;
  int m_hi = 0, m_lo = 0, m_co = 0;
  int m_won = 0, m_lost = 0;
  int m_ready = 0;  // a game is in progress and waiting for a guess

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"},   8'(guess_ready), 8'(m_ready));
    chk({tag, ".higher"},  8'(higher),      8'(m_hi));
    chk({tag, ".lower"},   8'(lower),       8'(m_lo));
    chk({tag, ".correct"}, 8'(correct),     8'(m_co));
    chk({tag, ".tries"},   8'(tries_left),  8'(m_tries));
    chk({tag, ".won"},     8'(won),         8'(m_won));
    chk({tag, ".lost"},    8'(lost),        8'(m_lost));
    chk({tag, ".secret"},  8'(secret_out),  8'((m_won || m_lost) ? m_secret : 0));
  endtask

  task automatic model_clear();
    m_secret = 0; m_tries = 0; m_hi = 0; m_lo = 0; m_co = 0;
    m_won = 0; m_lost = 0; m_ready = 0;
  endtask

  task automatic model_guess(input int g);
    m_tries = m_tries - 1;
    if (g == m_secret) begin
      m_co = 1; m_hi = 0; m_lo = 0; m_won = 1; m_ready = 0;
    end else begin
      m_co = 0;
      m_hi = (g < m_secret) ? 1 : 0;
      m_lo = (g > m_secret) ? 1 : 0;
      m_ready = (m_tries == 0) ? 0 : 1;
      m_lost  = (m_tries == 0) ? 1 : 0;
    end
  endtask

  // driver: pulse start for one edge; restarts unless a game is in progress
  task automatic do_start(input int rn, input string tag);
    random_number = W'(rn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!m_ready) begin
      m_secret = (rn > 10) ? rn - 11 : rn;
      m_tries = 5; m_hi = 0; m_lo = 0; m_co = 0;
      m_won = 0; m_lost = 0; m_ready = 1;
    end
    check_all(tag);
  endtask

  // driver: one guess transfer, checked at the accept edge and one edge later
  task automatic do_guess(input int g, input string tag);
    guess = W'(g);
    guess_valid = 1'b1;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    m_ready = 0;
    check_all({tag, ".acc"});
    @(posedge clk); #1;
    model_guess(g);
    check_all({tag, ".res"});
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // guess_valid asserted while no game is waiting: must be ignored
  task automatic ignored_guess(input int g, input string tag);
    guess = W'(g);
    guess_valid = 1'b1;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // reset
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    reset_n = 1'b1;
    idle_cycle("idle");
    ignored_guess(3, "idle_guess");

    // normal win
    do_start(7, "win.start");
    do_guess(3, "win.g3");
    do_guess(9, "win.g9");
    do_guess(7, "win.g7");
    ignored_guess(2, "win.ign");

    // loss, restarted straight from WIN
    do_start(2, "loss.start");
    for (int i = 0; i < 5; i++) do_guess(5, $sformatf("loss.g%0d", i));
    ignored_guess(2, "lose.ign");

    // fold 11 -> 0
    do_start(11, "fold.start");
    do_guess(0, "fold.g0");

    // secret 10, out-of-range guess, idle, start ignored during PLAY
    do_start(10, "b10.start");
    do_guess(15, "b10.g15");
    idle_cycle("b10.idle0");
    idle_cycle("b10.idle1");
    do_start(3, "b10.start_ign");
    do_guess(10, "b10.g10");

    // guess_valid held high: accept at E, none at E+1, accept at E+2
    do_start(5, "hs.start");
    guess = 4'd1;
    guess_valid = 1'b1;
    @(posedge clk); #1;
    m_ready = 0;
    check_all("hs.E");
    @(posedge clk); #1;
    model_guess(1);
    check_all("hs.E1");
    @(posedge clk); #1;
    m_ready = 0;
    check_all("hs.E2");
    @(posedge clk); #1;
    guess_valid = 1'b0;
    model_guess(1);
    check_all("hs.E3");

    // asynchronous reset mid-PLAY with tries_left=3, no clock edge needed
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all("arst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle("arst.idle");

    // last-try win, then restart
    do_start(6, "last.start");
    for (int i = 0; i < 4; i++) do_guess(0, $sformatf("last.g%0d", i));
    do_guess(6, "last.win");
    do_start(4, "rs.start");
    do_guess(4, "rs.g4");

    // randomized games against the model
    for (int game = 0; game < 25; game++) begin
      do_start($urandom_range(0, 11), $sformatf("rnd%0d.start", game));
      while (m_ready) begin
        int g;
        if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rnd%0d.idle", game));
        g = $urandom_range(0, 15);
        if ($urandom_range(0, 4) == 0) g = m_secret;
        do_guess(g, $sformatf("rnd%0d.g", game));
      end
      if ($urandom_range(0, 1) == 1) ignored_guess($urandom_range(0, 15), $sformatf("rnd%0d.ign", game));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #500000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
